signed_iter_divider: RTL and testbench

- Multi-cycle restoring divider for the ALU's DIV/REM path.
- Strips operand signs to magnitudes, divides the magnitudes, then re-applies the sign to quotient and remainder.
- Sits behind the ALU operand muxes; the ALU stalls while Busy is high.

---
 rtl/signed_iter_divider_pkg.sv | 15 +
 rtl/signed_iter_divider_if.sv | 28 ++
 rtl/signed_iter_divider_div_step.sv | 23 ++
 rtl/signed_iter_divider.sv | 148 ++++++++++++++
 tb/tb_signed_iter_divider.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/signed_iter_divider_pkg.sv
// Shared ALU divider definitions: FSM state encodings, default width and latency.
package signed_iter_divider_pkg;

    localparam int unsigned AluWidth   = 16;
    // Edges from the accepting Start edge to the edge that raises Done.
    localparam int unsigned DivLatency = AluWidth + 2;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StPrep = 2'd1,
        StIter = 2'd2,
        StFix  = 2'd3
    } div_state_e;

endpackage

// File: rtl/signed_iter_divider_if.sv
// Request/result bundle between the ALU operand muxes and the iterative divider.
interface signed_iter_divider_if
    import signed_iter_divider_pkg::*;
#(
    parameter int unsigned Width = AluWidth
) ();

    logic             start;
    logic             signed_op;
    logic [Width-1:0] a;
    logic [Width-1:0] b;
    logic             busy;
    logic             done;
    logic [Width-1:0] q;
    logic [Width-1:0] rem;
    logic             div_zero;

    modport master (
        output start, signed_op, a, b,
        input  busy, done, q, rem, div_zero
    );

    modport slave (
        input  start, signed_op, a, b,
        output busy, done, q, rem, div_zero
    );

endinterface

// File: rtl/signed_iter_divider_div_step.sv
// One combinational restoring-division step on the {rem, quo} shift pair.
module signed_iter_divider_div_step #(
    parameter int unsigned Width = 16
) (
    input  logic [Width-1:0] rem_i,
    input  logic [Width-1:0] quo_i,
    input  logic [Width-1:0] magb_i,
    output logic [Width-1:0] rem_o,
    output logic [Width-1:0] quo_o
);

    logic [Width:0] rem_sh;
    logic           ge;

    always_comb begin
        rem_sh = {rem_i, quo_i[Width-1]};
        ge     = rem_sh >= {1'b0, magb_i};
        // Difference is below magb_i, so it always fits in Width bits.
        rem_o  = ge ? (rem_sh[Width-1:0] - magb_i) : rem_sh[Width-1:0];
        quo_o  = {quo_i[Width-2:0], ge};
    end

endmodule

// File: rtl/signed_iter_divider.sv
// Multi-cycle signed/unsigned restoring divider (IDLE -> PREP -> ITER -> FIX).
// Define DIV_ZERO_FASTPATH_EN to skip ITER when the divisor is zero.
module signed_iter_divider
    import signed_iter_divider_pkg::*;
#(
    parameter int unsigned Width = AluWidth
) (
    input logic                 clk_i,
    input logic                 reset_i,
    signed_iter_divider_if.slave div_if
);

    localparam int unsigned Msb  = Width - 1;
    localparam int unsigned CntW = $clog2(Width + 1);

    div_state_e       state_q, state_d;
    logic [Width-1:0] a_q, a_d, b_q, b_d;
    logic             signed_q, signed_d;
    logic [Width-1:0] rem_q, rem_d, quo_q, quo_d, magb_q, magb_d;
    logic             sq_q, sq_d, sr_q, sr_d, dz_q, dz_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             done_q, done_d, div_zero_q, div_zero_d;
    logic [Width-1:0] res_q_q, res_q_d, res_rem_q, res_rem_d;

    logic             s_a, s_b;
    logic [Width-1:0] step_rem, step_quo;

    signed_iter_divider_div_step #(
        .Width(Width)
    ) u_div_step (
        .rem_i (rem_q),
        .quo_i (quo_q),
        .magb_i(magb_q),
        .rem_o (step_rem),
        .quo_o (step_quo)
    );

    assign s_a = signed_q & a_q[Msb];
    assign s_b = signed_q & b_q[Msb];

    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        signed_d   = signed_q;
        rem_d      = rem_q;
        quo_d      = quo_q;
        magb_d     = magb_q;
        sq_d       = sq_q;
        sr_d       = sr_q;
        dz_d       = dz_q;
        cnt_d      = cnt_q;
        done_d     = 1'b0;
        div_zero_d = div_zero_q;
        res_q_d    = res_q_q;
        res_rem_d  = res_rem_q;

        unique case (state_q)
            StIdle: begin
                if (div_if.start) begin
                    a_d      = div_if.a;
                    b_d      = div_if.b;
                    signed_d = div_if.signed_op;
                    state_d  = StPrep;
                end
            end
            StPrep: begin
                // The dividend magnitude is shifted out of quo as the quotient shifts in.
                quo_d  = s_a ? -a_q : a_q;
                magb_d = s_b ? -b_q : b_q;
                rem_d  = '0;
                sq_d   = s_a ^ s_b;
                sr_d   = s_a;
                dz_d   = (b_q == '0);
                cnt_d  = CntW'(Width);
`ifdef DIV_ZERO_FASTPATH_EN
                state_d = (b_q == '0) ? StFix : StIter;
`else
                state_d = StIter;
`endif
            end
            StIter: begin
                rem_d = step_rem;
                quo_d = step_quo;
                cnt_d = cnt_q - CntW'(1);
                if (cnt_q == CntW'(1)) begin
                    state_d = StFix;
                end
            end
            StFix: begin
                if (dz_q) begin
                    res_q_d   = '1;
                    res_rem_d = a_q;
                end else begin
                    res_q_d   = sq_q ? -quo_q : quo_q;
                    res_rem_d = sr_q ? -rem_q : rem_q;
                end
                div_zero_d = dz_q;
                done_d     = 1'b1;
                state_d    = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= StIdle;
            a_q        <= '0;
            b_q        <= '0;
            signed_q   <= 1'b0;
            rem_q      <= '0;
            quo_q      <= '0;
            magb_q     <= '0;
            sq_q       <= 1'b0;
            sr_q       <= 1'b0;
            dz_q       <= 1'b0;
            cnt_q      <= '0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
            res_q_q    <= '0;
            res_rem_q  <= '0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            signed_q   <= signed_d;
            rem_q      <= rem_d;
            quo_q      <= quo_d;
            magb_q     <= magb_d;
            sq_q       <= sq_d;
            sr_q       <= sr_d;
            dz_q       <= dz_d;
            cnt_q      <= cnt_d;
            done_q     <= done_d;
            div_zero_q <= div_zero_d;
            res_q_q    <= res_q_d;
            res_rem_q  <= res_rem_d;
        end
    end

    assign div_if.busy     = (state_q != StIdle);
    assign div_if.done     = done_q;
    assign div_if.q        = res_q_q;
    assign div_if.rem      = res_rem_q;
    assign div_if.div_zero = div_zero_q;

endmodule

// File: tb/tb_signed_iter_divider.sv
// Scoreboard bench for signed_iter_divider: expected results queued at Start, checked at Done.
module tb_signed_iter_divider;

    localparam int unsigned W       = 16;
    localparam int unsigned FullLat = W + 2;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] rem;
        logic         dz;
        int           start_cyc;
        int           lat;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc   = 0;
    exp_t sb[$];

    signed_iter_divider_if #(.Width(W)) div_if ();

    signed_iter_divider #(
        .Width(W)
    ) dut (
        .clk_i  (clk),
        .reset_i(reset),
        .div_if (div_if)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
        end
    endtask

    function automatic exp_t model(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t   e;
        longint sa, sbv;
        e.dz = (b == '0);
        if (b == '0) begin
            e.q   = '1;
            e.rem = a;
        end else if (sgn) begin
            sa    = $signed(a);
            sbv   = $signed(b);
            e.q   = W'(sa / sbv);
            e.rem = W'(sa % sbv);
        end else begin
            e.q   = a / b;
            e.rem = a % b;
        end
`ifdef DIV_ZERO_FASTPATH_EN
        e.lat = (b == '0) ? 2 : FullLat;
`else
        e.lat = FullLat;
`endif
        e.start_cyc = 0;
        return e;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (!reset && div_if.done) begin
            if (sb.size() == 0) begin
                check("spurious_done", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check("q", 32'(div_if.q), 32'(e.q));
                check("rem", 32'(div_if.rem), 32'(e.rem));
                check("div_zero", 32'(div_if.div_zero), 32'(e.dz));
                check("latency", 32'(cyc - e.start_cyc), 32'(e.lat));
            end
        end
    end

    task automatic wait_idle();
        for (int i = 0; i < 100 && div_if.busy; i++) @(negedge clk);
        if (div_if.busy) check("idle_timeout", 32'd1, 32'd0);
    endtask

    task automatic issue(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        wait_idle();
        e               = model(sgn, a, b);
        e.start_cyc     = cyc + 1;
        div_if.start     = 1'b1;
        div_if.signed_op = sgn;
        div_if.a         = a;
        div_if.b         = b;
        sb.push_back(e);
        @(negedge clk);
        div_if.start = 1'b0;
        check("busy_after_start", 32'(div_if.busy), 32'd1);
    endtask

    task automatic drain();
        int t = 0;
        while (sb.size() != 0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (sb.size() != 0) begin
            check("done_timeout", 32'(sb.size()), 32'd0);
            sb.delete();
        end
        @(negedge clk);
    endtask

    task automatic run_op(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b);
        issue(sgn, a, b);
        drain();
    endtask

    initial begin
        reset            = 1'b1;
        div_if.start     = 1'b0;
        div_if.signed_op = 1'b0;
        div_if.a         = '0;
        div_if.b         = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("rst_busy", 32'(div_if.busy), 32'd0);
        check("rst_done", 32'(div_if.done), 32'd0);
        check("rst_q", 32'(div_if.q), 32'd0);
        check("rst_rem", 32'(div_if.rem), 32'd0);
        check("rst_dz", 32'(div_if.div_zero), 32'd0);

        run_op(1'b1, 16'h0007, 16'hFFFE);
        run_op(1'b1, 16'hFFF9, 16'h0002);
        run_op(1'b1, 16'h8000, 16'hFFFF);
        run_op(1'b0, 16'hFFFF, 16'h0010);
        run_op(1'b0, 16'h0003, 16'h0005);
        run_op(1'b1, 16'hFFFB, 16'h0000);
        run_op(1'b0, 16'h1234, 16'h0000);

        // Second Start while busy must be dropped; first op's result returned.
        issue(1'b1, 16'h0064, 16'hFFF9);
        repeat (3) @(negedge clk);
        div_if.start     = 1'b1;
        div_if.signed_op = 1'b0;
        div_if.a         = 16'h5555;
        div_if.b         = 16'h0000;
        @(negedge clk);
        div_if.start = 1'b0;
        drain();
        repeat (W + 6) @(negedge clk);

        // Div-by-zero followed by a normal op: DivZero must clear again.
        run_op(1'b1, 16'hFFFB, 16'h0000);
        run_op(1'b1, 16'hFF9C, 16'h0007);

        // Reset in the middle of ITER aborts the operation.
        issue(1'b1, 16'h7FFF, 16'h0003);
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("abort_busy", 32'(div_if.busy), 32'd0);
        check("abort_done", 32'(div_if.done), 32'd0);
        check("abort_q", 32'(div_if.q), 32'd0);
        check("abort_rem", 32'(div_if.rem), 32'd0);
        sb.delete();
        reset = 1'b0;
        repeat (W + 6) @(negedge clk);
        run_op(1'b1, 16'h8001, 16'h0010);

        for (int i = 0; i < 10; i++) begin
            run_op(1'($urandom_range(1)), W'($urandom), W'($urandom_range(3) == 0 ?
                   $urandom_range(3) : $urandom));
        end

        repeat (5) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
